// File: rtl/i2c_master_write_byte_if.sv
// Bundle of byte-request handshake and downstream bit-writer signals.
interface i2c_master_write_byte_if;
  logic       go;
  logic [7:0] data;
  logic       finish;
  logic       busy;
  logic       bit_go;
  logic [2:0] bit_command;
  logic       bit_finish;

  modport master (
    input  go,
    input  data,
    input  bit_finish,
    output finish,
    output busy,
    output bit_go,
    output bit_command
  );

  modport slave (
    output go,
    output data,
    output bit_finish,
    input  finish,
    input  busy,
    input  bit_go,
    input  bit_command
  );
endinterface

// File: rtl/i2c_master_write_byte.sv
// Serialises one byte into eight four-phase requests to a downstream bit writer.
module i2c_master_write_byte #(
  parameter bit BIT_ORDER_MSB = 1'b1
) (
  input logic                          clock,
  input logic                          reset,
  i2c_master_write_byte_if.master      bus
);

  typedef enum logic [1:0] {StIdle, StReq, StRel, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] shreg_q;
  logic [2:0] cnt_q;
  logic       cur_bit;

  assign cur_bit = BIT_ORDER_MSB ? shreg_q[7] : shreg_q[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.go) state_d = StReq;
      StReq:  if (bus.bit_finish) state_d = StRel;
      StRel: begin
        if (!bus.bit_finish) state_d = (cnt_q == 3'd7) ? StDone : StReq;
      end
      StDone: if (!bus.go) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Counter only advances between bits, so it never wraps past 7.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg_q <= 8'h00;
      cnt_q   <= 3'd0;
    end else if (state_q == StIdle && bus.go) begin
      shreg_q <= bus.data;
      cnt_q   <= 3'd0;
    end else if (state_q == StRel && !bus.bit_finish && cnt_q != 3'd7) begin
      shreg_q <= BIT_ORDER_MSB ? {shreg_q[6:0], 1'b0} : {1'b0, shreg_q[7:1]};
      cnt_q   <= cnt_q + 3'd1;
    end
  end

  always_comb begin
    bus.finish      = 1'b0;
    bus.busy        = 1'b0;
    bus.bit_go      = 1'b0;
    bus.bit_command = 3'b000;
    unique case (state_q)
      StIdle: ;
      StReq: begin
        bus.busy        = 1'b1;
        bus.bit_go      = 1'b1;
        bus.bit_command = {2'b10, cur_bit};
      end
      StRel: bus.busy = 1'b1;
      StDone: begin
        bus.busy   = 1'b1;
        bus.finish = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_master_write_byte.sv
// Bench: MSB-first and LSB-first instances driven against a bit-writer model and command queue.
module tb_i2c_master_write_byte;

  logic clock;
  logic reset;
  int   checks;
  int   failures;
  int   pulses [2];
  int   dly [2];
  logic prev_go [2];
  bit   model_en;
  logic [2:0] exp_q [$];

  i2c_master_write_byte_if ia ();
  i2c_master_write_byte_if ib ();

  i2c_master_write_byte #(.BIT_ORDER_MSB(1'b1)) dut_msb (
    .clock (clock),
    .reset (reset),
    .bus   (ia)
  );

  i2c_master_write_byte #(.BIT_ORDER_MSB(1'b0)) dut_lsb (
    .clock (clock),
    .reset (reset),
    .bus   (ib)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {finish, busy, bit_go, bit_command}
  function automatic logic [5:0] outs(input int s);
    if (s == 0) return {ia.finish, ia.busy, ia.bit_go, ia.bit_command};
    return {ib.finish, ib.busy, ib.bit_go, ib.bit_command};
  endfunction

  function automatic logic get_bf(input int s);
    return (s == 0) ? ia.bit_finish : ib.bit_finish;
  endfunction

  task automatic set_bf(input int s, input logic v);
    if (s == 0) ia.bit_finish = v;
    else ib.bit_finish = v;
  endtask

  task automatic drive(input int s, input logic g, input logic [7:0] d);
    if (s == 0) begin
      ia.go = g;
      ia.data = d;
    end else begin
      ib.go = g;
      ib.data = d;
    end
  endtask

  // Bit-writer model: finish three cycles after each request, release after bit_go drops.
  initial begin
    for (int s = 0; s < 2; s++) begin
      pulses[s] = 0;
      dly[s] = 0;
      prev_go[s] = 1'b0;
    end
    forever begin
      @(negedge clock);
      for (int s = 0; s < 2; s++) begin
        logic [5:0] o;
        o = outs(s);
        if (reset) begin
          set_bf(s, 1'b0);
          dly[s] = 0;
          prev_go[s] = 1'b0;
          continue;
        end
        if (o[3] && !prev_go[s]) begin
          pulses[s]++;
          check("bit_go_rise_quiet", {30'd0, get_bf(s), o[5]}, 32'd0);
          if (exp_q.size() == 0) check("unexpected_bit_go", 32'd1, 32'd0);
          else check("bit_command", {29'd0, o[2:0]}, {29'd0, exp_q.pop_front()});
          dly[s] = 3;
        end else if (model_en && o[3] && dly[s] > 0) begin
          dly[s]--;
          if (dly[s] == 0) set_bf(s, 1'b1);
        end
        if (!o[3]) check("cmd_when_not_req", {29'd0, o[2:0]}, 32'd0);
        if (model_en && !o[3] && get_bf(s)) set_bf(s, 1'b0);
        prev_go[s] = o[3];
      end
    end
  end

  task automatic run_byte(input int s, input logic [7:0] d, input int drop_at,
                          input int rst_at);
    int   base;
    bit   done;
    bit   go_hi;
    bit   saw_go;
    logic [5:0] o;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({2'b10, (s == 0) ? d[7-i] : d[i]});
    end
    base = pulses[s];
    drive(s, 1'b1, d);
    go_hi = 1'b1;
    @(negedge clock);
    o = outs(s);
    check("accept_latency", {26'd0, o[4:3]}, 32'd3);
    drive(s, 1'b1, ~d);
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clock);
      if (rst_at > 0 && pulses[s] - base == rst_at) begin
        @(posedge clock);
        #2 reset = 1'b1;
        drive(s, 1'b0, 8'h00);
        #1 check("async_reset_outs", {26'd0, outs(s)}, 32'd0);
        exp_q.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        saw_go = 1'b0;
        repeat (6) begin
          @(negedge clock);
          if (outs(s) != 6'd0) saw_go = 1'b1;
        end
        check("no_start_after_reset", {31'd0, saw_go}, 32'd0);
        return;
      end
      if (drop_at > 0 && pulses[s] - base >= drop_at && go_hi) begin
        drive(s, 1'b0, ~d);
        go_hi = 1'b0;
      end
      if (outs(s) & 6'b100000) done = 1'b1;
    end
    if (!done) begin
      check("finish_timeout", 32'd0, 32'd1);
      drive(s, 1'b0, 8'h00);
      return;
    end
    check("bit_go_pulses", pulses[s] - base, 32'd8);
    check("queue_drained", exp_q.size(), 32'd0);
    if (go_hi) begin
      repeat (3) begin
        @(negedge clock);
        o = outs(s);
        check("done_hold", {26'd0, o}, {26'd0, 6'b110000});
      end
      drive(s, 1'b0, ~d);
    end
    @(negedge clock);
    check("return_idle", {26'd0, outs(s)}, 32'd0);
    @(negedge clock);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_en = 1'b1;
    reset = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    ia.bit_finish = 1'b0;
    ib.bit_finish = 1'b0;
    #1;
    check("reset_msb", {26'd0, outs(0)}, 32'd0);
    check("reset_lsb", {26'd0, outs(1)}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("no_start_on_release", {26'd0, outs(0)}, 32'd0);

    // bit_finish while idle must not wake the block
    model_en = 1'b0;
    ia.bit_finish = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_ignores_bit_finish", {26'd0, outs(0)}, 32'd0);
    ia.bit_finish = 1'b0;
    model_en = 1'b1;
    @(negedge clock);

    run_byte(0, 8'hA5, 0, 0);
    run_byte(1, 8'h01, 0, 0);
    run_byte(0, 8'h00, 0, 0);
    run_byte(0, 8'hC3, 2, 0);
    run_byte(0, 8'h96, 0, 4);
    run_byte(0, 8'h3C, 0, 0);
    run_byte(0, 8'h81, 0, 0);
    run_byte(0, 8'h7E, 0, 0);
    run_byte(1, 8'hB4, 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_master_write_byte.md
I2C_MASTER_WRITE_BYTE -- requirements
Module: i2c_master_write_byte

Interface
REQ-001 Parameter: BIT_ORDER_MSB, 1, 1 sends data[7] first; 0 sends data[0] first.
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 go  input  1  byte-transfer request; four-phase with finish.
REQ-005 data  input  8  byte to transmit; sampled only when a request is accepted.
REQ-006 finish  output  1  byte done; held high until go is low.
REQ-007 busy  output  1  high from request acceptance until return to IDLE.
REQ-008 bit_go  output  1  request to the downstream bit writer (drives its go).
REQ-009 bit_command  output  3  bit writer command: 3'b100 = data 0, 3'b101 = data 1; 3'b000 when not requesting.
REQ-010 bit_finish  input  1  completion from the bit writer (its finish); four-phase with bit_go.

Function
REQ-011 States SHALL be IDLE, REQ, REL and DONE; all outputs are Moore outputs decoded from registered state/datapath, with no combinational input-to-output path.
REQ-012 IDLE: finish=0, bit_go=0, busy=0, bit_command=3'b000; on go=1 at a clock edge, latch data into an 8-bit shift register, clear the 3-bit bit counter, and go to REQ.
REQ-013 REQ: bit_go=1, busy=1, bit_command={2'b10, current bit}; remain while bit_finish=0; on bit_finish=1 go to REL.
REQ-014 REL: bit_go=0, bit_command=3'b000; remain while bit_finish=1; on bit_finish=0 with counter==7 go to DONE, otherwise increment the counter, shift the register toward the next bit per BIT_ORDER_MSB, and go to REQ.
REQ-015 DONE: finish=1, busy=1; on go=0 go to IDLE; while go=1 remain in DONE.
REQ-016 Exactly 8 bit_go rising edges SHALL occur per accepted request; bit_go SHALL never rise while bit_finish=1.
REQ-017 Latency: bit_go rises on the first edge after go is sampled high; finish rises on the first edge after bit_finish is sampled low following the 8th bit.
REQ-018 Changes on data after acceptance SHALL NOT affect the byte in flight.
REQ-019 go falling mid-transfer SHALL NOT abort it; on reaching DONE with go=0, finish is high for exactly one cycle.
REQ-020 go held high through DONE into IDLE SHALL NOT start a new transfer until go has been seen low (guaranteed because DONE exits only on go=0).
REQ-021 bit_finish asserted while in IDLE or DONE SHALL be ignored.
REQ-022 Counter wrap from 7 SHALL NOT occur; the counter is reloaded only on acceptance.

Reset
REQ-023 reset=1 SHALL immediately force IDLE, finish=0, busy=0, bit_go=0, bit_command=3'b000, counter=0 and shift register=8'h00, independent of clock.
REQ-024 Reset mid-transfer SHALL discard the byte; after release the block waits in IDLE for a new go; the bit writer is reset concurrently by the integration.
REQ-025 Release of reset SHALL NOT by itself start a transfer; go must be sampled high at a post-reset edge.

Verification
REQ-026 BIT_ORDER_MSB=1, data=8'hA5, bit-writer model with a 3-cycle finish response -> bit_command sequence 101,100,101,100,100,101,100,101; then finish=1 until go drops.
REQ-027 BIT_ORDER_MSB=0, data=8'h01 -> first command 101, then seven 100; exactly 8 bit_go pulses.
REQ-028 data changed to 8'hFF after acceptance of 8'h00 -> all eight commands are 100.
REQ-029 go dropped after the 2nd bit -> transfer completes; finish high for exactly one cycle; returns to IDLE.
REQ-030 reset pulsed during the 4th bit -> bit_go, finish, busy and bit_command are 0 asynchronously; no further bit_go until a new go; the next byte 8'h3C is sent correctly.
REQ-031 go held high across two bytes with a go low phase between them -> two complete 8-bit sequences; no bit_go while finish=1.
